// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: handshake front-end that issues ADD/AND/XOR to the ALU and runs MULTIPLY as shift-add
module alu_op_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH+1:0]   in_instr,
  output logic [2*WIDTH+1:0]   alu_instr,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_ovf,
  input  logic                 alu_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_ovf,
  output logic                 out_carry,
  output logic                 busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_nx, partial;
  logic [CW-1:0] cnt;
  logic last;
  logic [WIDTH-1:0] oper1, oper2;
  assign oper1   = alu_instr[2*WIDTH-1:WIDTH];
  assign oper2   = alu_instr[WIDTH-1:0];
  assign last    = cnt == CW'(WIDTH-1);
  assign partial = oper2[cnt] ? ({{WIDTH{1'b0}}, oper1} << cnt) : '0;
  assign acc_nx  = acc + partial;
  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    busy      = state != IDLE;
    case (state)
      IDLE: state_nx = in_valid ? (in_instr[2*WIDTH+1:2*WIDTH] == 2'b11 ? MUL : EXEC) : IDLE;
      EXEC: state_nx = DONE;
      MUL:  state_nx = last ? DONE : MUL;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // instruction capture, multiplier iteration and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_instr  <= '0;
      acc        <= '0;
      cnt        <= '0;
      out_result <= '0;
      out_ovf    <= 1'b0;
      out_carry  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      alu_instr <= in_instr;
      acc       <= '0;
      cnt       <= '0;
    end else if (state == EXEC) begin
      out_result <= {{WIDTH{1'b0}}, alu_out};
      out_ovf    <= alu_ovf;
      out_carry  <= alu_carry;
    end else if (state == MUL) begin
      acc <= acc_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        out_result <= acc_nx;
        out_ovf    <= 1'b0;
        out_carry  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed vector table, reset corner cases and a random scoreboarded run
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic        in_ready, out_valid, out_ovf, out_carry, busy, alu_ovf, alu_carry;
  logic [17:0] in_instr, alu_instr;
  logic [7:0]  alu_out;
  logic [15:0] out_result;
  int checks = 0, errors = 0;

  alu_op_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_instr(alu_instr), .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_carry(out_carry), .busy(busy)
  );

  always #5 clk = ~clk;

  // external ALU model: {ovf, carry, out}; an overflowing ADD returns 0
  function automatic logic [9:0] alu_f(input logic [17:0] ins);
    logic [8:0] s;
    logic v;
    s = {1'b0, ins[15:8]} + {1'b0, ins[7:0]};
    v = (ins[15] == ins[7]) && (s[7] != ins[15]);
    case (ins[17:16])
      2'b00:   return {v, s[8], v ? 8'h00 : s[7:0]};
      2'b01:   return {2'b00, ins[15:8] & ins[7:0]};
      2'b10:   return {2'b00, ins[15:8] ^ ins[7:0]};
      default: return 10'h000;
    endcase
  endfunction

  assign {alu_ovf, alu_carry, alu_out} = alu_f(alu_instr);

  // expected {ovf, carry, result16} for any instruction
  function automatic logic [17:0] model(input logic [17:0] ins);
    logic [15:0] p;
    logic [9:0] r;
    if (ins[17:16] == 2'b11) begin
      p = {8'h00, ins[15:8]};
      p = p * {8'h00, ins[7:0]};
      return {2'b00, p};
    end
    r = alu_f(ins);
    return {r[9:8], 8'h00, r[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] res;
    logic        ovf;
    logic        carry;
  } vec_t;
  vec_t vecs[11];

  // one instruction: accept, latency, busy, result, hold stability, release
  task automatic do_op(input vec_t v);
    int lat, bad_busy, bad_hold;
    logic [17:0] ins;
    ins = {v.op, v.a, v.b};
    chk("idle_ready", 32'(in_ready), 32'd1);
    in_instr = ins; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 1; bad_busy = 0;
    while (!out_valid && lat < 30) begin
      if (!busy || in_ready) bad_busy++;
      tick();
      lat++;
    end
    chk("latency", 32'(lat), v.op == 2'b11 ? 32'd9 : 32'd2);
    chk("busy_inflight", 32'(bad_busy), 32'd0);
    chk("result", {14'h0, out_ovf, out_carry, out_result}, {14'h0, v.ovf, v.carry, v.res});
    bad_hold = 0;
    for (int i = 0; i < v.hold; i++) begin
      in_valid = 1'b1; in_instr = 18'h0_12_34;
      tick();
      if (!out_valid || in_ready || !busy || out_result !== v.res || out_ovf !== v.ovf ||
          out_carry !== v.carry || alu_instr !== ins) bad_hold++;
    end
    chk("hold_stable", 32'(bad_hold), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release", {30'h0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{2'b00, 8'h35, 8'h4A, 0, 16'h007F, 1'b0, 1'b0};
    vecs[1]  = '{2'b00, 8'h7F, 8'h01, 0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 8'hFF, 8'h01, 0, 16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{2'b11, 8'hFF, 8'hFF, 0, 16'hFE01, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 8'h00, 8'h9C, 0, 16'h0000, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 8'hAA, 8'hFF, 5, 16'h0055, 1'b0, 1'b0};
    vecs[6]  = '{2'b01, 8'hF0, 8'h3C, 0, 16'h0030, 1'b0, 1'b0};
    vecs[7]  = '{2'b00, 8'h80, 8'h80, 2, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{2'b11, 8'h12, 8'h34, 0, 16'h03A8, 1'b0, 1'b0};
    vecs[9]  = '{2'b11, 8'h80, 8'h02, 1, 16'h0100, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 8'h0F, 8'h10, 0, 16'h00F0, 1'b0, 1'b0};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("reset_state", {out_valid, in_ready, busy, out_ovf, out_carry, out_result, alu_instr},
        {5'b01000, 16'h0000, 18'h0});
    for (int i = 0; i < 11; i++) do_op(vecs[i]);
    // reset in cycle 4 of a multiply discards it
    in_instr = {2'b11, 8'h12, 8'h34}; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("mul_midway_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_mul_reset", {out_valid, in_ready, busy, out_result, alu_instr}, {3'b010, 16'h0, 18'h0});
    tick();
    chk("after_reset_idle", {30'h0, out_valid, in_ready}, 32'd1);
    // reset and in_valid at the same edge: no capture
    rst_n = 1'b0; in_valid = 1'b1; in_instr = {2'b00, 8'h11, 8'h22};
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    chk("reset_beats_valid", {13'h0, in_ready, alu_instr}, {13'h0, 1'b1, 18'h0});
    tick();
    chk("no_phantom_exec", {30'h0, busy, out_valid}, 32'd0);
    do_op(vecs[6]);
    // random back-to-back traffic against the scoreboard
    begin
      logic [17:0] q[$];
      int sent = 0, got = 0, cyc = 0;
      while ((sent < 200 || q.size() != 0) && cyc < 20000) begin
        in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
        in_instr  = 18'($urandom());
        out_ready = 1'($urandom_range(0, 1));
        if (in_valid && in_ready) begin
          q.push_back(model(in_instr));
          sent++;
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("rand_extra", 32'd1, 32'd0);
          else chk("rand_result", {14'h0, out_ovf, out_carry, out_result}, {14'h0, q.pop_front()});
          got++;
        end
        tick();
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("rand_count", 32'(got), 32'd200);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
